// File: rtl/alu_serial_sequencer.sv
// rtl/alu_serial_sequencer.sv - bit-serial operand sequencer driving a single 1-bit ALU slice
module alu_serial_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ALUCtrl,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] REZ,
  output logic             COUT,
  output logic             OVERFLOW,
  output logic             ZERO,
  output logic             ERR,
  output logic             ALU_A,
  output logic             ALU_B,
  output logic             ALU_CIN,
  output logic             ALU_BINV,
  output logic             ALU_LESS,
  output logic [2:0]       ALU_CTRL,
  input  logic             ALU_REZ,
  input  logic             ALU_COUT
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_q, b_q, rez_q, rez_upd;
  logic [2:0]       op_q;
  logic [CW-1:0]    cnt;
  logic             carry, cout_q, ovf_q, zero_q, err_q;
  logic             accept, supported, is_arith, is_slt, is_sub, last;

  assign supported = (ALUCtrl[2:1] != 2'b10);
  assign accept    = START && ((state == S_IDLE) || (state == S_DONE));
  assign is_arith  = (op_q == 3'b001) || (op_q == 3'b110);
  assign is_slt    = (op_q == 3'b111);
  assign is_sub    = (op_q == 3'b110) || is_slt;
  assign last      = (cnt == LAST);

  always_comb begin
    rez_upd      = rez_q;
    rez_upd[cnt] = ALU_REZ;
  end

  always_comb begin
    state_next = state;
    ALU_A      = 1'b0;
    ALU_B      = 1'b0;
    ALU_CIN    = 1'b0;
    ALU_BINV   = 1'b0;
    ALU_LESS   = 1'b0;
    ALU_CTRL   = 3'b000;
    case (state)
      S_IDLE, S_DONE: begin
        if (accept) begin
          state_next = supported ? S_RUN : S_DONE;
        end else if (state == S_DONE) begin
          state_next = S_IDLE;
        end
      end
      S_RUN: begin
        ALU_A    = a_q[cnt];
        ALU_B    = b_q[cnt];
        ALU_BINV = is_sub;
        // SLT runs the slice as a subtract; the sign bit is picked up at the end
        ALU_CTRL = is_slt ? 3'b110 : op_q;
        ALU_CIN  = (cnt == '0) ? is_sub : carry;
        if (last) begin
          state_next = S_DONE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state  <= S_IDLE;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= 3'b000;
      cnt    <= '0;
      carry  <= 1'b0;
      rez_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            rez_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            err_q  <= !supported;
            if (supported) begin
              a_q   <= A;
              b_q   <= B;
              op_q  <= ALUCtrl;
              cnt   <= '0;
              carry <= 1'b0;
            end
          end
        end
        S_RUN: begin
          rez_q <= rez_upd;
          carry <= ALU_COUT;
          cnt   <= cnt + CW'(1);
          if (last) begin
            cout_q <= is_arith & ALU_COUT;
            ovf_q  <= is_arith & (ALU_CIN ^ ALU_COUT);
            if (is_slt) begin
              rez_q  <= {{(WIDTH-1){1'b0}}, ALU_REZ};
              zero_q <= !ALU_REZ;
            end else begin
              zero_q <= (rez_upd == '0);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign BUSY     = (state == S_RUN);
  assign DONE     = (state == S_DONE);
  assign REZ      = rez_q;
  assign COUT     = cout_q;
  assign OVERFLOW = ovf_q;
  assign ZERO     = zero_q;
  assign ERR      = err_q;

endmodule

// File: tb/tb_alu_serial_sequencer.sv
// tb/tb_alu_serial_sequencer.sv - randomized self-checking bench with a behavioural 1-bit slice
module tb_alu_serial_sequencer;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst_n, start;
  logic [W-1:0]  a_in, b_in, rez;
  logic [2:0]    ctrl_in, alu_ctrl;
  logic          busy, done, cout, ovf, zero, err;
  logic          alu_a, alu_b, alu_cin, alu_binv, alu_less, alu_rez, alu_cout, bb;
  int            errors = 0;
  int            checks = 0;

  always #5 clk = ~clk;

  alu_serial_sequencer #(.WIDTH(W)) dut (
    .CLK(clk), .RST_N(rst_n), .START(start), .A(a_in), .B(b_in), .ALUCtrl(ctrl_in),
    .BUSY(busy), .DONE(done), .REZ(rez), .COUT(cout), .OVERFLOW(ovf), .ZERO(zero), .ERR(err),
    .ALU_A(alu_a), .ALU_B(alu_b), .ALU_CIN(alu_cin), .ALU_BINV(alu_binv), .ALU_LESS(alu_less),
    .ALU_CTRL(alu_ctrl), .ALU_REZ(alu_rez), .ALU_COUT(alu_cout)
  );

  // Behavioural ALU_1b slice
  assign bb       = alu_b ^ alu_binv;
  assign alu_cout = (alu_a & bb) | (alu_a & alu_cin) | (bb & alu_cin);
  always_comb begin
    alu_rez = 1'b0;
    case (alu_ctrl)
      3'b000:         alu_rez = alu_a & bb;
      3'b010:         alu_rez = alu_a | bb;
      3'b011:         alu_rez = alu_a ^ bb;
      3'b001, 3'b110: alu_rez = alu_a ^ bb ^ alu_cin;
      3'b111:         alu_rez = alu_less;
      default:        alu_rez = 1'b0;
    endcase
  end

  // Word-level reference: {err, zero, overflow, cout, rez}
  function automatic logic [19:0] model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    logic [15:0] r;
    logic c, v, e;
    s = '0; r = '0; c = 1'b0; v = 1'b0; e = 1'b0;
    case (op)
      3'b000: r = a & b;
      3'b010: r = a | b;
      3'b011: r = a ^ b;
      3'b001: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[15:0]; c = s[16];
        v = (a[15] == b[15]) && (r[15] != a[15]);
      end
      3'b110: begin
        s = {1'b0, a} + {1'b0, ~b} + 17'd1;
        r = s[15:0]; c = s[16];
        v = (a[15] != b[15]) && (r[15] != a[15]);
      end
      3'b111: begin
        s = {1'b0, a} - {1'b0, b};
        r = {15'b0, s[15]};
      end
      default: e = 1'b1;
    endcase
    return {e, (!e && r == 16'h0), v, c, r};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                        input int pulse_at, output int lat, output int busy_n, output int ctrl_bad,
                        output logic d1, output logic binv0, output logic cin0);
    logic [2:0] exp_ctrl;
    exp_ctrl = (op == 3'b111) ? 3'b110 : op;
    ctrl_in = op; a_in = a; b_in = b; start = 1'b1;
    step();
    start = 1'b0;
    lat = 1; busy_n = 0; ctrl_bad = 0;
    d1 = done; binv0 = alu_binv; cin0 = alu_cin;
    while (!done && lat < 40) begin
      if (busy) begin
        busy_n++;
        if (alu_ctrl !== exp_ctrl || alu_less !== 1'b0 || alu_a !== a[lat-1] || alu_b !== b[lat-1])
          ctrl_bad++;
      end
      start = (lat == pulse_at);
      if (start) begin
        a_in = ~a; b_in = a; ctrl_in = 3'b001;
      end
      step();
      lat++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a_in = '0; b_in = '0; ctrl_in = '0;
    step(); step();
    checks++;
    if ({busy, done, rez, cout, ovf, zero, err, alu_a, alu_b, alu_cin, alu_binv, alu_less, alu_ctrl} !== '0) begin
      errors++; $display("FAIL reset_outputs: some output nonzero, rez=%h busy=%b done=%b", rez, busy, done);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_idle: busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_add_overflow();
    int lat, bn, cb; logic d1, bi, ci;
    run_op(3'b001, 16'h7FFF, 16'h0001, 0, lat, bn, cb, d1, bi, ci);
    checks++;
    if (lat !== W + 1) begin errors++; $display("FAIL add_latency: got %0d expected %0d", lat, W + 1); end
    checks++;
    if (bn !== W) begin errors++; $display("FAIL add_busy_cycles: got %0d expected %0d", bn, W); end
    checks++;
    if ({err, zero, ovf, cout, rez} !== 20'h2_8000) begin
      errors++; $display("FAIL add_result: got %h expected %h", {err, zero, ovf, cout, rez}, 20'h2_8000);
    end
    checks++;
    if (cb !== 0 || d1 !== 1'b0) begin errors++; $display("FAIL add_drives: bad=%0d d1=%b expected 0 0", cb, d1); end
    step();
    checks++;
    if (done !== 1'b0 || rez !== 16'h8000) begin
      errors++; $display("FAIL add_hold: done=%b rez=%h expected 0 8000", done, rez);
    end
  endtask

  task automatic test_sub_zero();
    int lat, bn, cb; logic d1, bi, ci;
    run_op(3'b110, 16'h0005, 16'h0005, 0, lat, bn, cb, d1, bi, ci);
    checks++;
    if ({err, zero, ovf, cout, rez} !== 20'h5_0000) begin
      errors++; $display("FAIL sub_result: got %h expected %h", {err, zero, ovf, cout, rez}, 20'h5_0000);
    end
    checks++;
    if (bi !== 1'b1 || ci !== 1'b1) begin errors++; $display("FAIL sub_first_cycle: binv=%b cin=%b expected 1 1", bi, ci); end
    checks++;
    if (cb !== 0) begin errors++; $display("FAIL sub_drives: bad=%0d expected 0", cb); end
  endtask

  task automatic test_slt();
    int lat, bn, cb; logic d1, bi, ci;
    run_op(3'b111, 16'hFFFE, 16'h0003, 0, lat, bn, cb, d1, bi, ci);
    checks++;
    if ({err, zero, ovf, cout, rez} !== 20'h0_0001) begin
      errors++; $display("FAIL slt_neg: got %h expected %h", {err, zero, ovf, cout, rez}, 20'h0_0001);
    end
    checks++;
    if (cb !== 0) begin errors++; $display("FAIL slt_ctrl: bad=%0d expected 0", cb); end
    run_op(3'b111, 16'h8000, 16'h0001, 0, lat, bn, cb, d1, bi, ci);
    checks++;
    if ({err, zero, ovf, cout, rez} !== 20'h4_0000) begin
      errors++; $display("FAIL slt_uncorrected: got %h expected %h", {err, zero, ovf, cout, rez}, 20'h4_0000);
    end
  endtask

  task automatic test_xor_back_to_back();
    int lat, bn, cb; logic d1, bi, ci;
    run_op(3'b011, 16'hA5A5, 16'hFFFF, 5, lat, bn, cb, d1, bi, ci);
    checks++;
    if ({err, zero, ovf, cout, rez} !== 20'h0_5A5A || lat !== W + 1) begin
      errors++; $display("FAIL xor_ignore_start: got %h lat %0d expected %h lat %0d", {err, zero, ovf, cout, rez}, lat, 20'h0_5A5A, W + 1);
    end
    checks++;
    if (cb !== 0) begin errors++; $display("FAIL xor_operands: bad=%0d expected 0", cb); end
    run_op(3'b000, 16'hF0F0, 16'h3C3C, 0, lat, bn, cb, d1, bi, ci);
    checks++;
    if ({err, zero, ovf, cout, rez} !== 20'h0_3030 || lat !== W + 1 || d1 !== 1'b0) begin
      errors++; $display("FAIL back_to_back: got %h lat %0d d1 %b expected %h lat %0d d1 0", {err, zero, ovf, cout, rez}, lat, d1, 20'h0_3030, W + 1);
    end
  endtask

  task automatic test_unsupported();
    int lat, bn, cb; logic d1, bi, ci;
    step(); step();
    run_op(3'b100, 16'h1234, 16'h5678, 0, lat, bn, cb, d1, bi, ci);
    checks++;
    if (lat !== 1 || bn !== 0 || d1 !== 1'b1) begin
      errors++; $display("FAIL unsup_timing: lat=%0d busy=%0d d1=%b expected 1 0 1", lat, bn, d1);
    end
    checks++;
    if ({err, zero, ovf, cout, rez} !== 20'h8_0000) begin
      errors++; $display("FAIL unsup_result: got %h expected %h", {err, zero, ovf, cout, rez}, 20'h8_0000);
    end
    step();
    checks++;
    if (done !== 1'b0 || err !== 1'b1) begin errors++; $display("FAIL unsup_hold: done=%b err=%b expected 0 1", done, err); end
    run_op(3'b001, 16'h0001, 16'h0002, 0, lat, bn, cb, d1, bi, ci);
    checks++;
    if ({err, zero, ovf, cout, rez} !== model(3'b001, 16'h0001, 16'h0002)) begin
      errors++; $display("FAIL unsup_clear: got %h expected %h", {err, zero, ovf, cout, rez}, model(3'b001, 16'h0001, 16'h0002));
    end
  endtask

  task automatic test_reset_mid_run();
    int lat, bn, cb, dcount; logic d1, bi, ci;
    ctrl_in = 3'b001; a_in = 16'hFFFF; b_in = 16'h0001; start = 1'b1;
    step();
    start = 1'b0;
    repeat (7) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if ({busy, done, rez, cout, ovf, zero, err, alu_a, alu_b, alu_cin, alu_binv, alu_less, alu_ctrl} !== '0) begin
      errors++; $display("FAIL midrun_reset: outputs nonzero, busy=%b rez=%h", busy, rez);
    end
    dcount = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (done || busy) dcount++;
    end
    checks++;
    if (dcount !== 0) begin errors++; $display("FAIL midrun_no_done: active cycles=%0d expected 0", dcount); end
    run_op(3'b001, 16'h1234, 16'h1111, 0, lat, bn, cb, d1, bi, ci);
    checks++;
    if ({err, zero, ovf, cout, rez} !== 20'h0_2345 || lat !== W + 1) begin
      errors++; $display("FAIL midrun_restart: got %h lat %0d expected %h lat %0d", {err, zero, ovf, cout, rez}, lat, 20'h0_2345, W + 1);
    end
  endtask

  task automatic test_random();
    int lat, bn, cb; logic d1, bi, ci;
    logic [2:0] op; logic [15:0] a, b; logic [19:0] exp_v;
    for (int n = 0; n < 40; n++) begin
      op = 3'($urandom_range(0, 7));
      a = 16'($urandom);
      b = 16'($urandom);
      repeat ($urandom_range(0, 2)) step();
      run_op(op, a, b, 0, lat, bn, cb, d1, bi, ci);
      exp_v = model(op, a, b);
      checks++;
      if ({err, zero, ovf, cout, rez} !== exp_v || lat !== (exp_v[19] ? 1 : W + 1) || cb !== 0) begin
        errors++;
        $display("FAIL random_op%0d: op=%b a=%h b=%h got %h lat %0d bad %0d expected %h", n, op, a, b, {err, zero, ovf, cout, rez}, lat, cb, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_sub_zero();
    test_slt();
    test_xor_back_to_back();
    test_unsupported();
    test_reset_mid_run();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
